// File: rtl/cpu_controller.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Outputs are a Mealy decode of the state, the IR opcode, the flags and mem_ack.
module cpu_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       zero_flag,
  input  logic       carry_flag,
  input  logic       mem_ack,
  output logic [1:0] pc_sel,
  output logic       ir_ld,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic [1:0] alu_op,
  output logic       alu_imm,
  output logic       rf_we,
  output logic       wb_sel,
  output logic       flags_ld,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_ALU, S_MEM, S_BRANCH, S_HALT
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_LW   = 4'b1001;
  localparam logic [3:0] OP_SW   = 4'b1010;
  localparam logic [3:0] OP_JMP  = 4'b1011;
  localparam logic [3:0] OP_BZ   = 4'b1100;
  localparam logic [3:0] OP_BC   = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1110;
  localparam logic [3:0] OP_ILL  = 4'b1111;

  state_e     state_q, state_d;
  logic [3:0] op_m1;

  assign op_m1 = opcode - 4'd1;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pc_sel   = 2'b00;
    ir_ld    = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    alu_op   = 2'b00;
    alu_imm  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    flags_ld = 1'b0;
    halted   = 1'b0;
    illegal  = 1'b0;
    // Reset overrides decode so nothing leaks out of an abandoned instruction.
    if (!rst) begin
      unique case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_ld   = 1'b1;
            pc_sel  = 2'b01;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          unique case (opcode)
            OP_NOP:                state_d = S_FETCH;
            OP_ILL: begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
            OP_LW, OP_SW:          state_d = S_MEM;
            OP_JMP, OP_BZ, OP_BC:  state_d = S_BRANCH;
            OP_HALT:               state_d = S_HALT;
            default:               state_d = S_ALU;
          endcase
        end
        S_ALU: begin
          rf_we    = 1'b1;
          flags_ld = 1'b1;
          alu_op   = op_m1[1:0];
          alu_imm  = op_m1[2];
          state_d  = S_FETCH;
        end
        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (opcode == OP_SW);
          if (mem_ack) begin
            rf_we   = (opcode == OP_LW);
            wb_sel  = (opcode == OP_LW);
            state_d = S_FETCH;
          end
        end
        S_BRANCH: begin
          if ((opcode == OP_JMP) || (opcode == OP_BZ && zero_flag) ||
              (opcode == OP_BC && carry_flag))
            pc_sel = 2'b10;
          state_d = S_FETCH;
        end
        S_HALT: halted = 1'b1;
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed-vector bench for cpu_controller; expected output words are hand-computed per cycle.
module tb_cpu_controller;

  logic       clk, rst;
  logic [3:0] opcode;
  logic       zero_flag, carry_flag, mem_ack;
  logic [1:0] pc_sel, alu_op;
  logic       ir_ld, mem_req, mem_we, addr_sel, alu_imm, rf_we, wb_sel, flags_ld, halted, illegal;

  int checks = 0;
  int failures = 0;

  cpu_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero_flag(zero_flag),
    .carry_flag(carry_flag), .mem_ack(mem_ack), .pc_sel(pc_sel), .ir_ld(ir_ld),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .alu_op(alu_op),
    .alu_imm(alu_imm), .rf_we(rf_we), .wb_sel(wb_sel), .flags_ld(flags_ld),
    .halted(halted), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output word: {pc_sel,ir_ld,mem_req,mem_we,addr_sel,alu_op,alu_imm,rf_we,wb_sel,flags_ld,halted,illegal}
  function automatic logic [13:0] ov(logic [1:0] pc, logic ir, logic mr, logic mw, logic as_,
                                     logic [1:0] op, logic im, logic rw, logic wb, logic fl,
                                     logic h, logic il);
    return {pc, ir, mr, mw, as_, op, im, rw, wb, fl, h, il};
  endfunction

  localparam logic [13:0] O_ZERO  = 14'b0;
  localparam logic [13:0] O_FETCH = 14'b01_1_1_0_0_00_0_0_0_0_0_0;
  localparam logic [13:0] O_FWAIT = 14'b00_0_1_0_0_00_0_0_0_0_0_0;

  task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Inputs are set by the caller just after a rising edge; outputs sampled mid-cycle.
  task automatic cyc(input string tag, input logic [13:0] exp);
    #2;
    chk(tag, {pc_sel, ir_ld, mem_req, mem_we, addr_sel, alu_op, alu_imm,
              rf_we, wb_sel, flags_ld, halted, illegal}, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; opcode = 4'b0001; zero_flag = 1'b0; carry_flag = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    cyc("reset", O_ZERO);

    // ADD with mem_ack tied high: FETCH -> DECODE -> ALU, twice
    rst = 1'b0; mem_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc("add_fetch", O_FETCH);
      cyc("add_decode", O_ZERO);
      cyc("add_alu", ov(2'b00,0,0,0,0,2'b00,0,1,0,1,0,0));
    end

    // SUBI and ORI: alu_op from (opcode-1) mod 4, immediate operand
    opcode = 4'b0110;
    cyc("subi_fetch", O_FETCH);
    cyc("subi_decode", O_ZERO);
    cyc("subi_alu", ov(2'b00,0,0,0,0,2'b01,1,1,0,1,0,0));
    opcode = 4'b1000;
    cyc("ori_fetch", O_FETCH);
    cyc("ori_decode", O_ZERO);
    cyc("ori_alu", ov(2'b00,0,0,0,0,2'b11,1,1,0,1,0,0));

    // LW with four wait cycles in MEM
    opcode = 4'b1001;
    cyc("lw_fetch", O_FETCH);
    cyc("lw_decode", O_ZERO);
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) cyc("lw_wait", ov(2'b00,0,1,0,1,2'b00,0,0,0,0,0,0));
    mem_ack = 1'b1;
    cyc("lw_ack", ov(2'b00,0,1,0,1,2'b00,0,1,1,0,0,0));

    // SW
    opcode = 4'b1010;
    cyc("sw_fetch", O_FETCH);
    cyc("sw_decode", O_ZERO);
    cyc("sw_mem", ov(2'b00,0,1,1,1,2'b00,0,0,0,0,0,0));

    // Branches
    opcode = 4'b1100; zero_flag = 1'b1;
    cyc("bz1_fetch", O_FETCH);
    cyc("bz1_decode", O_ZERO);
    cyc("bz_taken", ov(2'b10,0,0,0,0,2'b00,0,0,0,0,0,0));
    zero_flag = 1'b0; carry_flag = 1'b1;
    cyc("bz0_fetch", O_FETCH);
    cyc("bz0_decode", O_ZERO);
    cyc("bz_not_taken", O_ZERO);
    opcode = 4'b1101; zero_flag = 1'b1; carry_flag = 1'b1;
    cyc("bc_fetch", O_FETCH);
    cyc("bc_decode", O_ZERO);
    cyc("bc_taken", ov(2'b10,0,0,0,0,2'b00,0,0,0,0,0,0));
    carry_flag = 1'b0;
    cyc("bc0_fetch", O_FETCH);
    cyc("bc0_decode", O_ZERO);
    cyc("bc_not_taken", O_ZERO);
    opcode = 4'b1011; zero_flag = 1'b0; carry_flag = 1'b0;
    cyc("jmp_fetch", O_FETCH);
    cyc("jmp_decode", O_ZERO);
    cyc("jmp_taken", ov(2'b10,0,0,0,0,2'b00,0,0,0,0,0,0));

    // Illegal opcode: 2-cycle instruction with a single illegal pulse
    opcode = 4'b1111;
    cyc("ill_fetch", O_FETCH);
    cyc("ill_decode", ov(2'b00,0,0,0,0,2'b00,0,0,0,0,0,1));
    opcode = 4'b1110;
    cyc("after_ill_fetch", O_FETCH);

    // HALT holds through toggling mem_ack
    cyc("halt_decode", O_ZERO);
    for (int i = 0; i < 20; i++) begin
      mem_ack = i[0];
      cyc("halt_hold", ov(2'b00,0,0,0,0,2'b00,0,0,0,0,1,0));
    end

    // Reset out of HALT, then reset during a FETCH wait
    rst = 1'b1; mem_ack = 1'b0;
    cyc("halt_rst", O_ZERO);
    rst = 1'b0;
    cyc("fetch_wait", O_FWAIT);
    rst = 1'b1; mem_ack = 1'b1;
    cyc("rst_in_wait", O_ZERO);
    rst = 1'b0; mem_ack = 1'b0;
    cyc("post_rst_fetch", O_FWAIT);
    mem_ack = 1'b1;
    cyc("post_rst_ack", O_FETCH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Multi-cycle control unit for the 8-bit accumulator/register-file CPU. It sequences fetch, decode and execute over the shared instruction/data memory, driving the PC update select, the 19-bit instruction register load, the register-file write, the ALU operation and the carry/zero flag loads. It sits beside the datapath and sees only the IR opcode field, the two flag-register outputs and the memory acknowledge.

## Interface
Parameters: none; all widths are fixed by the datapath.

- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset; synchronous and active-high
- opcode  in  4  IR[18:15] from the instruction register
- zero_flag  in  1  output of the zero-flag register
- carry_flag  in  1  output of the carry-flag register
- mem_ack  in  1  memory transfer complete; sampled only while mem_req=1
- pc_sel  out  2  selects the next PC: 00 hold, 01 PC+1, 10 IR[11:0] target
- ir_ld  out  1  load the instruction register from memory read data
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe; meaningful only with mem_req=1
- addr_sel  out  1  memory address: 0 = PC, 1 = IR[11:0]
- alu_op  out  2  ALU operation: 00 add, 01 sub, 10 and, 11 or
- alu_imm  out  1  ALU B operand: 1 = IR[7:0], 0 = register
- rf_we  out  1  register-file write enable
- wb_sel  out  1  write-back source: 0 = ALU, 1 = memory read data
- flags_ld  out  1  load carry and zero flags from the ALU
- halted  out  1  high while in HALT
- illegal  out  1  one-cycle pulse in DECODE for opcode 1111

## Operation
- States: FETCH, DECODE, ALU, MEM, BRANCH, HALT. The encoding is free.
- Every output is 0 (pc_sel=00) unless listed for the current state.
- FETCH
  - Drive mem_req=1, addr_sel=0.
  - If mem_ack=1: drive ir_ld=1 and pc_sel=01, then go to DECODE. Otherwise stay in FETCH.
- DECODE: no outputs except illegal. Next state by opcode:
  - 0000 NOP and 1111 illegal: go to FETCH. For 1111, pulse illegal.
  - 0001–0100 (ADD, SUB, AND, OR) and 0101–1000 (ADDI, SUBI, ANDI, ORI): go to ALU.
  - 1001 LW and 1010 SW: go to MEM.
  - 1011 JMP, 1100 BZ, 1101 BC: go to BRANCH.
  - 1110 HALT: go to HALT.
- ALU (one cycle)
  - Drive rf_we=1, wb_sel=0, flags_ld=1.
  - alu_op = (opcode−1) mod 4, so ADD/ADDI=00, SUB/SUBI=01, AND/ANDI=10, OR/ORI=11.
  - alu_imm=1 for opcodes 0101–1000.
  - Go to FETCH.
- MEM
  - Drive mem_req=1, addr_sel=1, and mem_we=1 if SW.
  - On mem_ack for LW: drive rf_we=1, wb_sel=1, then go to FETCH.
  - On mem_ack for SW: go to FETCH.
  - Without mem_ack: stay in MEM.
  - Flags are not affected by LW or SW.
- BRANCH (one cycle)
  - pc_sel=10 if JMP, if (BZ and zero_flag=1), or if (BC and carry_flag=1). Otherwise pc_sel=00.
  - Go to FETCH.
  - The target is absolute, IR[11:0]. The PC already holds PC+1 from FETCH, so a not-taken branch simply holds it.
- HALT: halted=1, pc_sel=00. Stays until rst; mem_ack is ignored.
- The opcode is latched by the caller's IR at the end of FETCH and is held stable through DECODE and execute. The controller does not re-register it; a private opcode copy is allowed.

## Timing
- Reset: rst=1 at a rising edge forces the state to FETCH. While rst=1, all outputs are driven 0, overriding state decode.
- The first mem_req appears in the first cycle with rst=0.
- Reset mid-instruction, including during a memory wait, abandons the instruction; no rf_we or ir_ld is issued in the reset cycle.
- mem_ack is a same-cycle acknowledge. With mem_ack tied high:
  - FETCH takes 1 cycle.
  - NOP and illegal: 2 cycles.
  - ALU, BRANCH, LW, SW: 3 cycles.
- Each wait cycle of mem_ack adds exactly one cycle in FETCH or MEM.
- mem_ack=1 while mem_req=0 (DECODE, ALU, BRANCH, HALT) has no effect.
- ir_ld, rf_we, flags_ld and pc_sel≠00 are each asserted for exactly one cycle per instruction.
- flags_ld in ALU and the branch decision never share a cycle, so a BZ immediately after SUB sees the updated zero_flag.

## Test plan
- Reset, then mem_ack tied high with opcode ADD (0001): the cycle sequence FETCH→DECODE→ALU repeats. ALU cycle shows rf_we=1, flags_ld=1, alu_op=00, alu_imm=0; ir_ld and pc_sel=01 appear once every 3 cycles.
- LW (1001) with mem_ack low for 4 MEM cycles, then high: mem_req=1 and addr_sel=1 held for 5 cycles, with rf_we=1 and wb_sel=1 only in the 5th; mem_we=0 throughout.
- SW (1010) with mem_ack high: one MEM cycle with mem_req=1, mem_we=1, rf_we=0.
- Branches:
  - BZ with zero_flag=1 gives pc_sel=10 in BRANCH; with zero_flag=0 it gives pc_sel=00.
  - BC with carry_flag=1 gives pc_sel=10.
  - JMP gives pc_sel=10 regardless of flags.
- Opcode 1111: illegal=1 for one cycle in DECODE, then back to FETCH with no rf_we, flags_ld or branch.
- HALT then rst:
  - halted=1 persists for 20 cycles with mem_ack toggling, with no mem_req.
  - Assert rst during a FETCH wait: all outputs are 0 in the reset cycle, and mem_req=1 with addr_sel=0 on the first cycle after rst falls.
